pipelined_adder: RTL and testbench

Parametrised, pipelined carry-chain adder for wide operands. Splits WIDTH-bit operands into CHUNK-bit slices and adds one slice per stage, so the carry path per cycle is only CHUNK bits. Accepts one operation per cycle under a valid/ready handshake with full back-pressure. Replaces the fixed 4-bit combinational adder wherever operands are wide or the adder sits on a timing-critical path.

---
 rtl/adder_pkg.sv | 17 +
 rtl/pipelined_adder_if.sv | 26 ++
 rtl/adder_stage.sv | 46 ++++
 rtl/pipelined_adder.sv | 121 ++++++++++++
 tb/tb_pipelined_adder.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared mode type and sizing helpers for pipelined_adder
package adder_pkg;

   typedef enum logic {
      ADD = 1'b0,
      SUB = 1'b1
   } mode_e;

   function automatic int stages(input int width, input int chunk);
      return width / chunk;
   endfunction

   function automatic bit geometry_ok(input int width, input int chunk);
      return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
   endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// rtl/pipelined_adder_if.sv - operand/result valid-ready bundle for pipelined_adder
interface pipelined_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] s2;
   logic             c;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             ovf;

   modport master (
      output in_valid, s1, s2, c, sub, out_ready,
      input  in_ready, out_valid, sum, carry, ovf
   );

   modport slave (
      input  in_valid, s1, s2, c, sub, out_ready,
      output in_ready, out_valid, sum, carry, ovf
   );
endinterface

// File: rtl/adder_stage.sv
// rtl/adder_stage.sv - one CHUNK-bit slice of pipelined_adder: slice add, carry out, valid bit
// The slice holding the operand sign bits also registers the signed overflow flag.
module adder_stage #(
   parameter int CHUNK     = 4,
   parameter bit MSB_SLICE = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             valid_in,
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic             valid,
   output logic [CHUNK-1:0] s,
   output logic             cout,
   output logic             ovf
);
   logic [CHUNK:0] total;

   assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         s     <= '0;
         cout  <= 1'b0;
      end else if (en) begin
         valid <= valid_in;
         s     <= total[CHUNK-1:0];
         cout  <= total[CHUNK];
      end
   end

   if (MSB_SLICE) begin : g_ovf
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            ovf <= 1'b0;
         end else if (en) begin
            ovf <= (a[CHUNK-1] == b[CHUNK-1]) && (total[CHUNK-1] != a[CHUNK-1]);
         end
      end
   end else begin : g_no_ovf
      assign ovf = 1'b0;
   end
endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - WIDTH-bit adder computing one CHUNK-bit slice per pipeline stage
// Build option ADDER_SUB_EN: adds the subtract datapath selected per operation by bus.sub.
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input logic              clk,
   input logic              rst_n,
   pipelined_adder_if.slave bus
);
   localparam int STAGES = stages(WIDTH, CHUNK);

   if (!geometry_ok(WIDTH, CHUNK)) begin : g_bad_geometry
      $error("pipelined_adder: WIDTH must be a non-zero multiple of CHUNK");
   end

   logic              advance;
   logic [WIDTH-1:0]  b_eff;
   logic [STAGES:0]   valid_v;
   logic [STAGES:0]   carry_v;
   logic [STAGES-1:0] ovf_v;
   logic [WIDTH-1:0]  result;

`ifdef ADDER_SUB_EN
   mode_e mode;

   // Subtract folds into the add: a + ~b + ~borrow_in.
   assign mode       = mode_e'(bus.sub);
   assign b_eff      = (mode == SUB) ? ~bus.s2 : bus.s2;
   assign carry_v[0] = (mode == SUB) ? ~bus.c : bus.c;
`else
   assign b_eff      = bus.s2;
   assign carry_v[0] = bus.c;
`endif

   assign advance    = !valid_v[STAGES] || bus.out_ready;
   assign valid_v[0] = bus.in_valid;

   for (genvar k = 0; k < STAGES; k++) begin : g_slice
      logic [CHUNK-1:0] a_k;
      logic [CHUNK-1:0] b_k;
      logic [CHUNK-1:0] s_k;

      // Operand slice k waits k cycles so it meets the carry from slice k-1.
      if (k == 0) begin : g_in_direct
         assign a_k = bus.s1[CHUNK-1:0];
         assign b_k = b_eff[CHUNK-1:0];
      end else begin : g_in_skew
         logic [CHUNK-1:0] a_q [k];
         logic [CHUNK-1:0] b_q [k];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < k; i++) begin
                  a_q[i] <= '0;
                  b_q[i] <= '0;
               end
            end else if (advance) begin
               a_q[0] <= bus.s1[k*CHUNK +: CHUNK];
               b_q[0] <= b_eff[k*CHUNK +: CHUNK];
               for (int i = 1; i < k; i++) begin
                  a_q[i] <= a_q[i-1];
                  b_q[i] <= b_q[i-1];
               end
            end
         end

         assign a_k = a_q[k-1];
         assign b_k = b_q[k-1];
      end

      adder_stage #(
         .CHUNK     (CHUNK),
         .MSB_SLICE (k == STAGES - 1)
      ) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .en       (advance),
         .valid_in (valid_v[k]),
         .a        (a_k),
         .b        (b_k),
         .cin      (carry_v[k]),
         .valid    (valid_v[k+1]),
         .s        (s_k),
         .cout     (carry_v[k+1]),
         .ovf      (ovf_v[k])
      );

      // Result slice k waits for the remaining STAGES-1-k slices to finish.
      if (k == STAGES - 1) begin : g_out_direct
         assign result[k*CHUNK +: CHUNK] = s_k;
      end else begin : g_out_skew
         localparam int DLY = STAGES - 1 - k;
         logic [CHUNK-1:0] r_q [DLY];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < DLY; i++) begin
                  r_q[i] <= '0;
               end
            end else if (advance) begin
               r_q[0] <= s_k;
               for (int i = 1; i < DLY; i++) begin
                  r_q[i] <= r_q[i-1];
               end
            end
         end

         assign result[k*CHUNK +: CHUNK] = r_q[DLY-1];
      end
   end

   assign bus.in_ready  = advance;
   assign bus.out_valid = valid_v[STAGES];
   assign bus.sum       = result;
   assign bus.carry     = carry_v[STAGES];
   // Only the MSB slice drives a non-zero flag.
   assign bus.ovf       = |ovf_v;
endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - randomized scoreboard bench for pipelined_adder at 16/4, 32/8 and 8/8
module tb_pipelined_adder;

`ifdef ADDER_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif
   localparam int NVEC  = 6;
   localparam int NRAND = 10000;

   typedef struct packed {
      logic [31:0] s1;
      logic [31:0] s2;
      logic        c;
      logic        sub;
   } vec_t;

   logic clk;
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic; returns {ovf, carry, sum[31:0]}.
   function automatic logic [33:0] model(input int w, input longint a, input longint b,
                                         input bit cin, input bit sub);
      longint m, half, r, sa, sb, sr;
      bit     cy, ov;
      m    = longint'(1) << w;
      half = m / 2;
      sa   = (a >= half) ? a - m : a;
      sb   = (b >= half) ? b - m : b;
      if (sub) begin
         r  = a - b - longint'(cin);
         cy = (r >= 0);
         sr = sa - sb - longint'(cin);
      end else begin
         r  = a + b + longint'(cin);
         cy = (r >= m);
         sr = sa + sb + longint'(cin);
      end
      ov = (sr < -half) || (sr >= half);
      r  = r & (m - 1);
      return {ov, cy, r[31:0]};
   endfunction

   function automatic vec_t vec(input int i);
      case (i)
         0:       return '{32'hFFFF, 32'h0001, 1'b0, 1'b0};
         1:       return '{32'h7FFF, 32'h0001, 1'b0, 1'b0};
         2:       return '{32'h0005, 32'h0007, 1'b0, 1'b1};
         3:       return '{32'h0010, 32'h0001, 1'b1, 1'b1};
         4:       return '{32'hFFFF, 32'hFFFF, 1'b1, 1'b0};
         default: return '{32'h8000, 32'h8000, 1'b0, 1'b0};
      endcase
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int W = (g == 0) ? 16 : ((g == 1) ? 32 : 8);
      localparam int C = (g == 0) ? 4 : 8;
      localparam int S = W / C;

      logic         rst_n;
      logic         fin;
      logic [33:0]  exp_q [$];
      logic [33:0]  e;
      logic [W-1:0] hold_sum;
      logic         hold_c;
      logic         hold_o;
      logic         stalled;
      int           lat;
      int           n_out;
      int           sent;
      int           cyc;
      int           target;
      vec_t         v;

      pipelined_adder_if #(.WIDTH(W)) bus ();

      pipelined_adder #(.WIDTH(W), .CHUNK(C)) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );

      initial begin
         fin           = 1'b0;
         rst_n         = 1'b0;
         bus.in_valid  = 1'b0;
         bus.out_ready = 1'b1;
         bus.s1        = '0;
         bus.s2        = '0;
         bus.c         = 1'b0;
         bus.sub       = 1'b0;
         repeat (2) @(negedge clk);
         check($sformatf("w%0d/rst_out_valid", W), 64'(bus.out_valid), 64'(0));
         check($sformatf("w%0d/rst_in_ready", W), 64'(bus.in_ready), 64'(1));
         check($sformatf("w%0d/rst_result", W), 64'({bus.ovf, bus.carry, bus.sum}), 64'(0));
         rst_n = 1'b1;

         // Phase 0: 8 back-to-back ops with a 3-cycle stall; phase 1: random handshakes.
         for (int phase = 0; phase < 2; phase++) begin
            sent    = 0;
            cyc     = 0;
            n_out   = 0;
            stalled = 1'b0;
            target  = (phase == 0) ? 8 : NRAND;
            while ((sent < target || exp_q.size() != 0) && cyc < 30 * target + 100) begin
               @(negedge clk);
               if (stalled) begin
                  check($sformatf("w%0d/hold_valid", W), 64'(bus.out_valid), 64'(1));
                  check($sformatf("w%0d/hold_result", W), 64'({bus.ovf, bus.carry, bus.sum}),
                        64'({hold_o, hold_c, hold_sum}));
               end
               if (phase == 0) begin
                  bus.in_valid  = (sent < target);
                  bus.out_ready = !(cyc >= 5 && cyc < 8);
               end else begin
                  bus.in_valid  = (sent < target) && ($urandom_range(3) != 0);
                  bus.out_ready = ($urandom_range(2) != 0);
               end
               bus.s1  = W'($urandom);
               bus.s2  = W'($urandom);
               bus.c   = 1'($urandom_range(1));
               bus.sub = 1'($urandom_range(1));
               #1;
               if (bus.out_valid && bus.out_ready) begin
                  n_out++;
                  if (exp_q.size() == 0) begin
                     check($sformatf("w%0d/spurious_result", W), 64'(1), 64'(0));
                  end else begin
                     e = exp_q.pop_front();
                     check($sformatf("w%0d/stream_result", W),
                           64'({bus.ovf, bus.carry, 32'(bus.sum)}), 64'(e));
                  end
               end
               stalled = bus.out_valid && !bus.out_ready;
               if (stalled) begin
                  check($sformatf("w%0d/stall_in_ready", W), 64'(bus.in_ready), 64'(0));
                  hold_sum = bus.sum;
                  hold_c   = bus.carry;
                  hold_o   = bus.ovf;
               end else begin
                  check($sformatf("w%0d/go_in_ready", W), 64'(bus.in_ready), 64'(1));
               end
               if (bus.in_valid && bus.in_ready) begin
                  exp_q.push_back(model(W, longint'(bus.s1), longint'(bus.s2), bus.c,
                                        SUB_EN && bus.sub));
                  sent++;
               end
               cyc++;
            end
            check($sformatf("w%0d/p%0d_drained", W, phase), 64'(exp_q.size()), 64'(0));
            check($sformatf("w%0d/p%0d_count", W, phase), 64'(n_out), 64'(target));
         end

         // Reset with operations in flight and the output stalled.
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b0;
            bus.s1        = W'($urandom);
            bus.s2        = W'($urandom);
         end
         @(negedge clk);
         bus.in_valid = 1'b0;
         @(negedge clk);
         check($sformatf("w%0d/pre_rst_valid", W), 64'(bus.out_valid), 64'(1));
         rst_n = 1'b0;
         #1;
         check($sformatf("w%0d/mid_rst_valid", W), 64'(bus.out_valid), 64'(0));
         check($sformatf("w%0d/mid_rst_result", W), 64'({bus.ovf, bus.carry, bus.sum}), 64'(0));
         repeat (2) @(negedge clk);
         rst_n         = 1'b1;
         bus.out_ready = 1'b1;
         @(negedge clk);
         check($sformatf("w%0d/post_rst_idle", W), 64'(bus.out_valid), 64'(0));

         // Directed corner vectors, one at a time, latency measured from acceptance.
         for (int i = 0; i < NVEC; i++) begin
            v = vec(i);
            @(negedge clk);
            bus.s1       = W'(v.s1);
            bus.s2       = W'(v.s2);
            bus.c        = v.c;
            bus.sub      = v.sub;
            bus.in_valid = 1'b1;
            e = model(W, longint'(bus.s1), longint'(bus.s2), bus.c, SUB_EN && bus.sub);
            @(negedge clk);
            bus.in_valid = 1'b0;
            lat = 1;
            while (!bus.out_valid && lat < S + 4) begin
               @(negedge clk);
               lat++;
            end
            check($sformatf("w%0d/v%0d_latency", W, i), 64'(lat), 64'(S));
            check($sformatf("w%0d/v%0d_result", W, i),
                  64'({bus.ovf, bus.carry, 32'(bus.sum)}), 64'(e));
         end

         @(negedge clk);
         fin = 1'b1;
      end
   end

   initial begin
      bit all_fin;
      all_fin = 1'b0;
      for (int t = 0; t < 80000 && !all_fin; t++) begin
         @(posedge clk);
         all_fin = g_dut[0].fin && g_dut[1].fin && g_dut[2].fin;
      end
      check("all_done", 64'(all_fin), 64'(1));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
